// File: rtl/rename_reg_file_if.sv
// Issue/lookup/commit bundle between decoder, issue stage, ROB and the rename register file.
interface rename_reg_file_if #(
   parameter int unsigned NUM_REGS = 32,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ROB_ID_W = 4,
   parameter int unsigned NUM_RS   = 2
);
   localparam int unsigned REG_IDX_W = $clog2(NUM_REGS);

   logic                         rdy;

   logic                         id_valid;
   logic                         id_rd_valid;
   logic [REG_IDX_W-1:0]         id_rd;
   logic [ROB_ID_W-1:0]          id_rd_rob_id;
   logic [NUM_RS-1:0]            id_rs_valid;
   logic [NUM_RS*REG_IDX_W-1:0]  id_rs;

   logic                         lk_valid;
   logic [NUM_RS-1:0]            lk_need;
   logic [NUM_RS-1:0]            lk_ready;
   logic [NUM_RS*DATA_W-1:0]     lk_value;
   logic [NUM_RS*ROB_ID_W-1:0]   lk_rob_id;

   logic                         cm_valid;
   logic [REG_IDX_W-1:0]         cm_rd;
   logic [ROB_ID_W-1:0]          cm_rob_id;
   logic [DATA_W-1:0]            cm_value;

   logic                         rollback;
   logic [REG_IDX_W:0]           busy_count;

   modport master (
      output rdy, id_valid, id_rd_valid, id_rd, id_rd_rob_id, id_rs_valid, id_rs,
      output cm_valid, cm_rd, cm_rob_id, cm_value, rollback,
      input  lk_valid, lk_need, lk_ready, lk_value, lk_rob_id, busy_count
   );

   modport slave (
      input  rdy, id_valid, id_rd_valid, id_rd, id_rd_rob_id, id_rs_valid, id_rs,
      input  cm_valid, cm_rd, cm_rob_id, cm_value, rollback,
      output lk_valid, lk_need, lk_ready, lk_value, lk_rob_id, busy_count
   );
endinterface

// File: rtl/rename_reg_file.sv
// Architectural register file with per-register busy bit + ROB tag and a registered lookup stage.
// Optional feature: define RENAME_RF_COMMIT_BYPASS_EN to forward same-cycle commits to lookups.
module rename_reg_file #(
   parameter int unsigned NUM_REGS = 32,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ROB_ID_W = 4,
   parameter int unsigned NUM_RS   = 2
) (
   input logic                  i_clk,
   input logic                  i_rst_n,
   rename_reg_file_if.slave     io_bus
);
   localparam int unsigned REG_IDX_W = $clog2(NUM_REGS);
   localparam int unsigned CNT_W     = REG_IDX_W + 1;

   // Interface unpacking
   logic                         w_rdy;
   logic                         w_id_valid;
   logic                         w_id_rd_valid;
   logic [REG_IDX_W-1:0]         w_id_rd;
   logic [ROB_ID_W-1:0]          w_id_rd_rob_id;
   logic [NUM_RS-1:0]            w_id_rs_valid;
   logic [NUM_RS*REG_IDX_W-1:0]  w_id_rs;
   logic                         w_cm_valid;
   logic [REG_IDX_W-1:0]         w_cm_rd;
   logic [ROB_ID_W-1:0]          w_cm_rob_id;
   logic [DATA_W-1:0]            w_cm_value;
   logic                         w_rollback_in;

   assign w_rdy          = io_bus.rdy;
   assign w_id_valid     = io_bus.id_valid;
   assign w_id_rd_valid  = io_bus.id_rd_valid;
   assign w_id_rd        = io_bus.id_rd;
   assign w_id_rd_rob_id = io_bus.id_rd_rob_id;
   assign w_id_rs_valid  = io_bus.id_rs_valid;
   assign w_id_rs        = io_bus.id_rs;
   assign w_cm_valid     = io_bus.cm_valid;
   assign w_cm_rd        = io_bus.cm_rd;
   assign w_cm_rob_id    = io_bus.cm_rob_id;
   assign w_cm_value     = io_bus.cm_value;
   assign w_rollback_in  = io_bus.rollback;

   // Architectural and rename state
   logic [DATA_W-1:0]    r_regs [NUM_REGS];
   logic [ROB_ID_W-1:0]  r_tag  [NUM_REGS];
   logic [NUM_REGS-1:0]  r_busy;
   logic [NUM_REGS-1:0]  w_busy_d;
   logic [CNT_W-1:0]     w_busy_cnt;

   // Registered lookup outputs
   logic                         r_lk_valid;
   logic [NUM_RS-1:0]            r_lk_need;
   logic [NUM_RS-1:0]            r_lk_ready;
   logic [NUM_RS*DATA_W-1:0]     r_lk_value;
   logic [NUM_RS*ROB_ID_W-1:0]   r_lk_rob_id;
   logic [CNT_W-1:0]             r_busy_count;

   logic [NUM_RS-1:0]            w_lk_ready_d;
   logic [NUM_RS*DATA_W-1:0]     w_lk_value_d;
   logic [NUM_RS*ROB_ID_W-1:0]   w_lk_rob_id_d;

   // Qualified events; rollback squashes the same cycle's issue and lookup but not its commit
   logic w_rollback;
   logic w_issue;
   logic w_commit;
   logic w_clear;
   logic w_lookup;

   assign w_rollback = w_rdy & w_rollback_in;
   assign w_issue    = w_rdy & w_id_valid & w_id_rd_valid & (w_id_rd != '0) & ~w_rollback_in;
   assign w_commit   = w_rdy & w_cm_valid & (w_cm_rd != '0);
   assign w_clear    = w_commit & (r_tag[w_cm_rd] == w_cm_rob_id);
   assign w_lookup   = w_rdy & w_id_valid & ~w_rollback_in;

   // Issue is applied after the clear so a same-rd issue keeps the register renamed
   always_comb begin
      w_busy_d = r_busy;
      if (w_rollback) begin
         w_busy_d = '0;
      end else begin
         if (w_clear) begin
            w_busy_d[w_cm_rd] = 1'b0;
         end
         if (w_issue) begin
            w_busy_d[w_id_rd] = 1'b1;
         end
      end
   end

   always_comb begin
      w_busy_cnt = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         w_busy_cnt = w_busy_cnt + CNT_W'(w_busy_d[i]);
      end
   end

   // Per-port operand resolution from pre-edge state
   for (genvar p = 0; p < NUM_RS; p++) begin : g_port
      logic [REG_IDX_W-1:0] w_src;
      logic                 w_need;
      logic                 w_src_busy;
      logic [ROB_ID_W-1:0]  w_src_tag;
      logic                 w_is_x0;
      logic                 w_byp;
      logic                 w_ready;

      assign w_src      = w_id_rs[p*REG_IDX_W +: REG_IDX_W];
      assign w_need     = w_id_rs_valid[p];
      assign w_src_busy = r_busy[w_src];
      assign w_src_tag  = r_tag[w_src];
      assign w_is_x0    = (w_src == '0);

`ifdef RENAME_RF_COMMIT_BYPASS_EN
      assign w_byp = w_commit & (w_cm_rd == w_src) & (~w_src_busy | (w_src_tag == w_cm_rob_id));
`else
      assign w_byp = 1'b0;
`endif

      assign w_ready = w_need & (w_is_x0 | w_byp | ~w_src_busy);

      assign w_lk_ready_d[p] = w_ready;

      assign w_lk_value_d[p*DATA_W +: DATA_W] =
         (!w_need || w_is_x0) ? '0         :
         w_byp                ? w_cm_value :
         w_src_busy           ? '0         : r_regs[w_src];

      assign w_lk_rob_id_d[p*ROB_ID_W +: ROB_ID_W] = (w_need && !w_ready) ? w_src_tag : '0;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= '0;
            r_tag[i]  <= '0;
         end
         r_busy <= '0;
      end else if (w_rdy) begin
         r_busy <= w_busy_d;
         if (w_commit) begin
            r_regs[w_cm_rd] <= w_cm_value;
         end
         if (w_issue) begin
            r_tag[w_id_rd] <= w_id_rd_rob_id;
         end
      end
   end

   // lk_* data holds between lookups; lk_valid is a single-cycle pulse
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_lk_valid   <= 1'b0;
         r_lk_need    <= '0;
         r_lk_ready   <= '0;
         r_lk_value   <= '0;
         r_lk_rob_id  <= '0;
         r_busy_count <= '0;
      end else if (w_rdy) begin
         r_lk_valid   <= w_lookup;
         r_busy_count <= w_busy_cnt;
         if (w_lookup) begin
            r_lk_need   <= w_id_rs_valid;
            r_lk_ready  <= w_lk_ready_d;
            r_lk_value  <= w_lk_value_d;
            r_lk_rob_id <= w_lk_rob_id_d;
         end
      end
   end

   assign io_bus.lk_valid   = r_lk_valid;
   assign io_bus.lk_need    = r_lk_need;
   assign io_bus.lk_ready   = r_lk_ready;
   assign io_bus.lk_value   = r_lk_value;
   assign io_bus.lk_rob_id  = r_lk_rob_id;
   assign io_bus.busy_count = r_busy_count;

endmodule

// File: tb/tb_rename_reg_file.sv
// Scoreboard bench for rename_reg_file: stimulus pushes expected lookups, a monitor pops and checks.
module tb_rename_reg_file;
   localparam int unsigned NR = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned RW = 4;
   localparam int unsigned NS = 2;
   localparam int unsigned IW = 5;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   rename_reg_file_if #(.NUM_REGS(NR), .DATA_W(DW), .ROB_ID_W(RW), .NUM_RS(NS)) bus ();

   rename_reg_file #(.NUM_REGS(NR), .DATA_W(DW), .ROB_ID_W(RW), .NUM_RS(NS)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .io_bus  (bus)
   );

   typedef struct {
      string       name;
      logic [1:0]  need;
      logic [1:0]  ready;
      logic [31:0] v0;
      logic [31:0] v1;
      logic [3:0]  r0;
      logic [3:0]  r1;
      logic [5:0]  cnt;
   } exp_t;

   exp_t q[$];
   int   n_pass  = 0;
   int   n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic push(input string name, input logic [1:0] need, input logic [1:0] ready,
                       input logic [31:0] v0, input logic [31:0] v1,
                       input logic [3:0] r0, input logic [3:0] r1, input logic [5:0] cnt);
      exp_t e;
      e.name = name; e.need = need; e.ready = ready;
      e.v0 = v0; e.v1 = v1; e.r0 = r0; e.r1 = r1; e.cnt = cnt;
      q.push_back(e);
   endtask

   task automatic clear_in();
      bus.rdy          = 1'b1;
      bus.id_valid     = 1'b0;
      bus.id_rd_valid  = 1'b0;
      bus.id_rd        = '0;
      bus.id_rd_rob_id = '0;
      bus.id_rs_valid  = '0;
      bus.id_rs        = '0;
      bus.cm_valid     = 1'b0;
      bus.cm_rd        = '0;
      bus.cm_rob_id    = '0;
      bus.cm_value     = '0;
      bus.rollback     = 1'b0;
   endtask

   task automatic set_id(input logic rdv, input logic [4:0] rd, input logic [3:0] tag,
                         input logic [1:0] rsv, input logic [4:0] s0, input logic [4:0] s1);
      bus.id_valid     = 1'b1;
      bus.id_rd_valid  = rdv;
      bus.id_rd        = rd;
      bus.id_rd_rob_id = tag;
      bus.id_rs_valid  = rsv;
      bus.id_rs        = {s1, s0};
   endtask

   task automatic set_cm(input logic [4:0] rd, input logic [3:0] tag, input logic [31:0] val);
      bus.cm_valid  = 1'b1;
      bus.cm_rd     = rd;
      bus.cm_rob_id = tag;
      bus.cm_value  = val;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      clear_in();
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".lk_valid"},   {31'b0, bus.lk_valid}, 32'h0);
      chk({tag, ".lk_need"},    {30'b0, bus.lk_need},  32'h0);
      chk({tag, ".lk_ready"},   {30'b0, bus.lk_ready}, 32'h0);
      chk({tag, ".lk_value0"},  bus.lk_value[31:0],    32'h0);
      chk({tag, ".lk_value1"},  bus.lk_value[63:32],   32'h0);
      chk({tag, ".lk_rob_id"},  {24'b0, bus.lk_rob_id}, 32'h0);
      chk({tag, ".busy_count"}, {26'b0, bus.busy_count}, 32'h0);
   endtask

   // Monitor: every lk_valid cycle must match the oldest queued expectation
   initial begin : monitor
      exp_t        e;
      logic [31:0] ev;
      logic [31:0] av;
      logic [3:0]  er;
      logic [3:0]  ar;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && bus.lk_valid === 1'b1) begin
            if (q.size() == 0) begin
               n_total++;
               $display("FAIL unexpected_lk_valid: got lk_valid=1 expected no lookup result");
            end else begin
               e = q.pop_front();
               chk({e.name, ".need"},  {30'b0, bus.lk_need},  {30'b0, e.need});
               chk({e.name, ".ready"}, {30'b0, bus.lk_ready}, {30'b0, e.ready});
               chk({e.name, ".busy_count"}, {26'b0, bus.busy_count}, {26'b0, e.cnt});
               for (int p = 0; p < 2; p++) begin
                  ev = (p == 0) ? e.v0 : e.v1;
                  er = (p == 0) ? e.r0 : e.r1;
                  av = (p == 0) ? bus.lk_value[31:0] : bus.lk_value[63:32];
                  ar = (p == 0) ? bus.lk_rob_id[3:0] : bus.lk_rob_id[7:4];
                  if (e.need[p] && e.ready[p])
                     chk($sformatf("%s.value%0d", e.name, p), av, ev);
                  if (e.need[p] && !e.ready[p])
                     chk($sformatf("%s.rob_id%0d", e.name, p), {28'b0, ar}, {28'b0, er});
               end
            end
         end
      end
   end

   initial begin : stimulus
      clear_in();
      rst_n = 1'b0;
      #3;
      chk_all_zero("reset");
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Basic lookup after reset
      set_id(1'b0, 5'd0, 4'd0, 2'b01, 5'd5, 5'd0);
      push("r5_after_reset", 2'b01, 2'b01, 32'h0, 32'h0, 4'd0, 4'd0, 6'd0);
      tick();

      // Issue r3 tag 7 while reading r3: own rename must not be seen
      set_id(1'b1, 5'd3, 4'd7, 2'b01, 5'd3, 5'd0);
      push("own_rename_hidden", 2'b01, 2'b01, 32'h0, 32'h0, 4'd0, 4'd0, 6'd1);
      tick();
      set_id(1'b0, 5'd0, 4'd0, 2'b11, 5'd3, 5'd0);
      push("r3_busy", 2'b11, 2'b10, 32'h0, 32'h0, 4'd7, 4'd0, 6'd1);
      tick();
      set_cm(5'd3, 4'd7, 32'h1234);
      tick();
      set_id(1'b0, 5'd0, 4'd0, 2'b01, 5'd3, 5'd0);
      push("r3_committed", 2'b01, 2'b01, 32'h1234, 32'h0, 4'd0, 4'd0, 6'd0);
      tick();

      // Stale commit leaves younger rename in place
      set_id(1'b1, 5'd4, 4'd2, 2'b00, 5'd0, 5'd0);
      push("r4_tag2", 2'b00, 2'b00, 32'h0, 32'h0, 4'd0, 4'd0, 6'd1);
      tick();
      set_id(1'b1, 5'd4, 4'd5, 2'b00, 5'd0, 5'd0);
      push("r4_tag5", 2'b00, 2'b00, 32'h0, 32'h0, 4'd0, 4'd0, 6'd1);
      tick();
      set_cm(5'd4, 4'd2, 32'h9);
      tick();
      set_id(1'b0, 5'd0, 4'd0, 2'b11, 5'd4, 5'd3);
      push("stale_commit", 2'b11, 2'b10, 32'h0, 32'h1234, 4'd5, 4'd0, 6'd1);
      tick();

      // x0 ignores issue and commit
      set_id(1'b1, 5'd0, 4'd3, 2'b00, 5'd0, 5'd0);
      push("x0_issue", 2'b00, 2'b00, 32'h0, 32'h0, 4'd0, 4'd0, 6'd1);
      tick();
      set_cm(5'd0, 4'd3, 32'hFF);
      tick();
      set_id(1'b0, 5'd0, 4'd0, 2'b11, 5'd0, 5'd4);
      push("x0_read", 2'b11, 2'b01, 32'h0, 32'h0, 4'd0, 4'd5, 6'd1);
      tick();

      // Rollback with concurrent issue, lookup and commit
      set_id(1'b1, 5'd1, 4'd1, 2'b00, 5'd0, 5'd0);
      push("ren_r1", 2'b00, 2'b00, 32'h0, 32'h0, 4'd0, 4'd0, 6'd2);
      tick();
      set_id(1'b1, 5'd2, 4'd2, 2'b00, 5'd0, 5'd0);
      push("ren_r2", 2'b00, 2'b00, 32'h0, 32'h0, 4'd0, 4'd0, 6'd3);
      tick();
      set_id(1'b1, 5'd3, 4'd3, 2'b00, 5'd0, 5'd0);
      push("ren_r3", 2'b00, 2'b00, 32'h0, 32'h0, 4'd0, 4'd0, 6'd4);
      tick();
      set_id(1'b1, 5'd6, 4'd6, 2'b01, 5'd1, 5'd0);
      set_cm(5'd1, 4'd1, 32'hA);
      bus.rollback = 1'b1;
      tick();
      chk("rollback.lk_valid",   {31'b0, bus.lk_valid},   32'h0);
      chk("rollback.busy_count", {26'b0, bus.busy_count}, 32'h0);
      set_id(1'b0, 5'd0, 4'd0, 2'b11, 5'd1, 5'd6);
      push("after_rollback_a", 2'b11, 2'b11, 32'hA, 32'h0, 4'd0, 4'd0, 6'd0);
      tick();
      set_id(1'b0, 5'd0, 4'd0, 2'b11, 5'd4, 5'd2);
      push("after_rollback_b", 2'b11, 2'b11, 32'h9, 32'h0, 4'd0, 4'd0, 6'd0);
      tick();
      tick();

      // rdy low freezes everything
      set_id(1'b1, 5'd9, 4'd9, 2'b11, 5'd1, 5'd9);
      set_cm(5'd1, 4'd1, 32'h77);
      bus.rdy = 1'b0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      chk("rdy_low.lk_valid",   {31'b0, bus.lk_valid},   32'h0);
      chk("rdy_low.busy_count", {26'b0, bus.busy_count}, 32'h0);
      clear_in();
      set_id(1'b0, 5'd0, 4'd0, 2'b11, 5'd1, 5'd9);
      push("rdy_freeze", 2'b11, 2'b11, 32'hA, 32'h0, 4'd0, 4'd0, 6'd0);
      tick();

      // Same-cycle commit and lookup of r8
      set_id(1'b1, 5'd8, 4'd1, 2'b00, 5'd0, 5'd0);
      push("ren_r8", 2'b00, 2'b00, 32'h0, 32'h0, 4'd0, 4'd0, 6'd1);
      tick();
      set_cm(5'd8, 4'd1, 32'h55);
      set_id(1'b0, 5'd0, 4'd0, 2'b01, 5'd8, 5'd0);
`ifdef RENAME_RF_COMMIT_BYPASS_EN
      push("r8_bypass", 2'b01, 2'b01, 32'h55, 32'h0, 4'd0, 4'd0, 6'd0);
`else
      push("r8_no_bypass", 2'b01, 2'b00, 32'h0, 32'h0, 4'd1, 4'd0, 6'd0);
`endif
      tick();
      set_id(1'b0, 5'd0, 4'd0, 2'b01, 5'd8, 5'd0);
      push("r8_after", 2'b01, 2'b01, 32'h55, 32'h0, 4'd0, 4'd0, 6'd0);
      tick();

      // Issue and commit to the same rd in one cycle
      set_id(1'b1, 5'd10, 4'd3, 2'b00, 5'd0, 5'd0);
      push("ren_r10", 2'b00, 2'b00, 32'h0, 32'h0, 4'd0, 4'd0, 6'd1);
      tick();
      set_cm(5'd10, 4'd3, 32'h66);
      set_id(1'b1, 5'd10, 4'd4, 2'b00, 5'd0, 5'd0);
      push("r10_issue_commit", 2'b00, 2'b00, 32'h0, 32'h0, 4'd0, 4'd0, 6'd1);
      tick();
      set_id(1'b0, 5'd0, 4'd0, 2'b01, 5'd10, 5'd0);
      push("r10_retagged", 2'b01, 2'b00, 32'h0, 32'h0, 4'd4, 4'd0, 6'd1);
      tick();

      // Asynchronous reset between edges
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk_all_zero("mid_reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      set_id(1'b0, 5'd0, 4'd0, 2'b11, 5'd3, 5'd10);
      push("post_reset", 2'b11, 2'b11, 32'h0, 32'h0, 4'd0, 4'd0, 6'd0);
      tick();
      tick();
      tick();
      chk("queue_drained", q.size(), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
